pkt_sched: RTL

Egress-side read scheduler for the packet cache. It watches the cache's advertised head packet ID and buffered-packet count, and issues one read request (ID + strobe) at a time when the downstream port has room. It then forwards the returned 134-bit packet stream and its tail-valid flag downstream through one register stage, and keeps sent/dropped statistics. It sits between the cache's read side and the egress port logic, and is the requester that drives the cache's ID input.

---
 rtl/pkt_sched_pkg.sv | 21 ++
 rtl/pkt_sched_stat.sv | 35 +++
 rtl/pkt_sched.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pkt_sched_pkg.sv
// Shared widths, header encodings and FSM state type for the packet-cache
// egress read scheduler.
package pkt_sched_pkg;

    localparam int DATA_W = 134;
    localparam int ID_W   = 8;
    localparam int CNT_W  = 5;

    // Word type lives in the two MSBs of every returned word.
    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_MID  = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_XFER
    } state_e;

endpackage

// File: rtl/pkt_sched_stat.sv
// Sent/dropped packet statistics: two free-running 32-bit counters that
// wrap to zero.
module pkt_sched_stat (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_wr_i,
    input  logic        valid_i,
    input  logic        timeout_i,
    output logic [31:0] sent_cnt_o,
    output logic [31:0] drop_cnt_o
);

    logic [31:0] sent_q;
    logic [31:0] drop_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_q <= '0;
            drop_q <= '0;
        end else begin
            if (valid_wr_i && valid_i) begin
                sent_q <= sent_q + 32'd1;
            end
            if ((valid_wr_i && !valid_i) || timeout_i) begin
                drop_q <= drop_q + 32'd1;
            end
        end
    end

    assign sent_cnt_o = sent_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: rtl/pkt_sched.sv
// Egress read scheduler: requests one packet at a time from the cache and
// forwards the returned stream downstream through one register stage.
module pkt_sched
    import pkt_sched_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int GAP     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ID_W-1:0]   in_pkt_sched_ID,
    input  logic [CNT_W-1:0]  in_pkt_sched_ID_count,
    output logic [ID_W-1:0]   out_pkt_sched_ID,
    output logic              out_pkt_sched_ID_wr,
    input  logic              in_pkt_sched_data_wr,
    input  logic [DATA_W-1:0] in_pkt_sched_data,
    input  logic              in_pkt_sched_valid_wr,
    input  logic              in_pkt_sched_valid,
    input  logic              in_pkt_sched_alf,
    output logic              out_pkt_sched_data_wr,
    output logic [DATA_W-1:0] out_pkt_sched_data,
    output logic              out_pkt_sched_valid_wr,
    output logic              out_pkt_sched_valid,
    output logic [31:0]       out_pkt_sched_sent_cnt,
    output logic [31:0]       out_pkt_sched_drop_cnt,
    output logic              out_pkt_sched_timeout
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = $clog2(GAP + 1);

    state_e            state_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [GAP_W-1:0]  gap_q;
    logic [ID_W-1:0]   id_q;
    logic              id_wr_q;
    logic              timeout_q;
    logic              data_wr_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_wr_q;
    logic              valid_q;

    logic in_pkt;
    logic tmo_evt;

    // Only end-of-packet strobes answering our own request are counted.
    assign in_pkt  = (state_q == ST_WAIT) || (state_q == ST_XFER);
    assign tmo_evt = (state_q == ST_WAIT) && !in_pkt_sched_valid_wr &&
                     !in_pkt_sched_data_wr && (tmo_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            gap_q     <= '0;
            id_q      <= '0;
            id_wr_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            id_wr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - 1'b1;
                    end else if (en && (in_pkt_sched_ID_count != '0) && !in_pkt_sched_alf) begin
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    id_q    <= in_pkt_sched_ID;
                    id_wr_q <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (in_pkt_sched_valid_wr) begin
                        state_q <= ST_IDLE;
                        gap_q   <= GAP_W'(GAP);
                    end else if (in_pkt_sched_data_wr) begin
                        state_q <= ST_XFER;
                    end else if (tmo_evt) begin
                        state_q   <= ST_IDLE;
                        gap_q     <= GAP_W'(GAP);
                        timeout_q <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (in_pkt_sched_valid_wr) begin
                        state_q <= ST_IDLE;
                        gap_q   <= GAP_W'(GAP);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The forwarding stage is reset too: it drives outputs that must read 0
    // the moment reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_wr_q  <= 1'b0;
            data_q     <= '0;
            valid_wr_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            data_wr_q  <= in_pkt_sched_data_wr;
            valid_wr_q <= in_pkt_sched_valid_wr;
            if (in_pkt_sched_data_wr) begin
                data_q <= in_pkt_sched_data;
            end
            if (in_pkt_sched_valid_wr) begin
                valid_q <= in_pkt_sched_valid;
            end
        end
    end

    pkt_sched_stat u_stat (
        .clk        (clk),
        .rst        (rst),
        .valid_wr_i (in_pkt && in_pkt_sched_valid_wr),
        .valid_i    (in_pkt_sched_valid),
        .timeout_i  (tmo_evt),
        .sent_cnt_o (out_pkt_sched_sent_cnt),
        .drop_cnt_o (out_pkt_sched_drop_cnt)
    );

    assign out_pkt_sched_ID       = id_q;
    assign out_pkt_sched_ID_wr    = id_wr_q;
    assign out_pkt_sched_timeout  = timeout_q;
    assign out_pkt_sched_data_wr  = data_wr_q;
    assign out_pkt_sched_data     = data_q;
    assign out_pkt_sched_valid_wr = valid_wr_q;
    assign out_pkt_sched_valid    = valid_q;

endmodule
